regfile_19bit: RTL and testbench

REGFILE_19BIT -- requirements
Module: regfile_19bit

---
 rtl/regfile_19bit.sv | 47 ++++
 tb/tb_regfile_19bit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_19bit.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file: one synchronous write port, two combinational read ports.
// Optional REGFILE_WRITE_BYPASS_EN forwards write_data to a read port addressing the register being written.
module regfile_19bit #(
    parameter int unsigned DATA_WIDTH = 19,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Storage: reset clears every entry and overrides any concurrent write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[write_addr] <= write_data;
        end
    end

    // Read ports: index the array directly, forwarding the in-flight write when bypass is built in.
    always_comb begin
        read_data1 = regs[read_addr1];
        read_data2 = regs[read_addr2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (rst && write_enable && (read_addr1 == write_addr)) begin
            read_data1 = write_data;
        end
        if (rst && write_enable && (read_addr2 == write_addr)) begin
            read_data2 = write_data;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_19bit.sv
// Self-checking bench for regfile_19bit: array model updated by the stimulus, per-cycle compare, directed literal checks.
module tb_regfile_19bit;

    localparam int unsigned DW = 19;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] read_addr1;
    logic [AW-1:0] read_addr2;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          write_enable;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;

    logic [DW-1:0] model [NR];
    int checks   = 0;
    int failures = 0;
    bit run      = 0;

    regfile_19bit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .read_addr1(read_addr1), .read_addr2(read_addr2),
        .write_addr(write_addr), .write_data(write_data),
        .write_enable(write_enable),
        .read_data1(read_data1), .read_data2(read_data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
`ifdef REGFILE_WRITE_BYPASS_EN
        if (rst && write_enable && a == write_addr) return write_data;
`endif
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    // One clock edge; the model takes the write the DUT was offered at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst && write_enable) model[write_addr] = write_data;
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_enable = 1'b1;
        write_addr   = a;
        write_data   = d;
        tick();
        write_enable = 1'b0;
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("port1_vs_model", read_data1, exp_read(read_addr1));
            chk("port2_vs_model", read_data2, exp_read(read_addr2));
        end
    end

    initial begin
        clear_model();
        rst          = 1'b0;
        write_enable = 1'b1;
        write_addr   = 5'd7;
        write_data   = 19'h00003;
        read_addr1   = 5'd7;
        read_addr2   = 5'd0;
        run          = 1'b1;

        // Writes offered during reset are discarded.
        repeat (3) tick();
        chk("write_during_reset", read_data1, 19'h00000);

        // First edge after release with write_enable high performs the write.
        rst = 1'b1;
        tick();
        write_enable = 1'b0;
        chk("first_write_after_release", read_data1, 19'h00003);

        for (int i = 0; i < 8; i++) wr(5'(i * 4 + 1), 19'($urandom));

        // Asynchronous reset then full scan of both ports.
        rst = 1'b0;
        clear_model();
        for (int a = 0; a < NR; a++) begin
            read_addr1 = 5'(a);
            read_addr2 = 5'(NR - 1 - a);
            #1;
            chk("reset_scan_p1", read_data1, 19'h00000);
            chk("reset_scan_p2", read_data2, 19'h00000);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;

        wr(5'd0, 19'h1ABCD);
        wr(5'd31, 19'h4F0F0);
        read_addr1 = 5'd0;
        read_addr2 = 5'd31;
        #1;
        chk("reg0_writable", read_data1, 19'h1ABCD);
        chk("reg31_writable", read_data2, 19'h4F0F0);

        wr(5'd5, 19'h55555);
        read_addr1 = 5'd5;
        #1;
        chk("reg5_pattern", read_data1, 19'h55555);

        wr(5'd10, 19'h7FFFF);
        read_addr2 = 5'd10;
        #1;
        chk("reg10_all_ones", read_data2, 19'h7FFFF);
        chk("reg5_kept", read_data1, 19'h55555);

        // Disabled write must not disturb the addressed register.
        write_enable = 1'b0;
        write_addr   = 5'd5;
        write_data   = 19'h12345;
        tick();
        chk("we0_no_write", read_data1, 19'h55555);

        // Read-during-write on both ports.
        wr(5'd3, 19'h2AAAA);
        read_addr1   = 5'd3;
        read_addr2   = 5'd3;
        write_enable = 1'b1;
        write_addr   = 5'd3;
        write_data   = 19'h00001;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("rdw_before_p1", read_data1, 19'h00001);
        chk("rdw_before_p2", read_data2, 19'h00001);
`else
        chk("rdw_before_p1", read_data1, 19'h2AAAA);
        chk("rdw_before_p2", read_data2, 19'h2AAAA);
`endif
        tick();
        write_enable = 1'b0;
        #1;
        chk("rdw_after_p1", read_data1, 19'h00001);
        chk("rdw_after_p2", read_data2, 19'h00001);

        // Mixed traffic checked by the per-cycle compare.
        for (int i = 0; i < 60; i++) begin
            write_enable = 1'($urandom_range(0, 1));
            write_addr   = 5'($urandom);
            write_data   = 19'($urandom);
            read_addr1   = (i % 4 == 0) ? write_addr : 5'($urandom);
            read_addr2   = 5'($urandom);
            tick();
        end

        // Mid-cycle reset with non-zero registers selected and a write pending.
        write_enable = 1'b0;
        wr(5'd5, 19'h0F0F0);
        wr(5'd10, 19'h3C3C3);
        read_addr1   = 5'd5;
        read_addr2   = 5'd10;
        write_enable = 1'b1;
        write_addr   = 5'd5;
        write_data   = 19'h11111;
        #2;
        rst = 1'b0;
        clear_model();
        #1;
        chk("async_reset_p1", read_data1, 19'h00000);
        chk("async_reset_p2", read_data2, 19'h00000);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        rst          = 1'b1;
        #1;
        chk("reset_dominates_write", read_data1, 19'h00000);

        repeat (3) tick();
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
